// File: rtl/updown_counter_arbiter.sv
// Round-robin arbiter driving a shared 3-bit up/down counter for two requesters (IDLE/RUN/DONE FSM).
// Optional macro SAT_GUARD_EN: stop the operation early instead of wrapping the counter.
module updown_counter_arbiter #(
    parameter int LEN_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             dir0,
    input  logic             dir1,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    input  logic [2:0]       count,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             cnt_en,
    output logic             up_down,
    output logic             sat_err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [LEN_W-1:0] remaining;
    logic             favour1;
    logic             run_en;
    logic             win1;
    logic             win_dir;
    logic [LEN_W-1:0] win_len;
    logic             sat_hit;

    assign win1    = req1 & (~req0 | favour1);
    assign win_dir = win1 ? dir1 : dir0;
    assign win_len = win1 ? len1 : len0;

`ifdef SAT_GUARD_EN
    // up_down holds the latched direction for the whole operation
    assign sat_hit = (state == RUN) && (up_down ? (count == 3'd7) : (count == 3'd0));
    assign cnt_en  = run_en & ~sat_hit;
`else
    logic unused_count;
    assign unused_count = ^count;
    assign sat_hit      = 1'b0;
    assign cnt_en       = run_en;
    assign sat_err      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            run_en    <= 1'b0;
            up_down   <= 1'b0;
            favour1   <= 1'b0;
            remaining <= '0;
`ifdef SAT_GUARD_EN
            sat_err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        gnt0      <= ~win1;
                        gnt1      <= win1;
                        favour1   <= ~win1;
                        remaining <= win_len;
                        if (win_len == '0) begin
                            state <= DONE;
                            done0 <= ~win1;
                            done1 <= win1;
                        end else begin
                            state   <= RUN;
                            run_en  <= 1'b1;
                            up_down <= win_dir;
                        end
                    end
                end
                RUN: begin
                    if (sat_hit || remaining == LEN_W'(1)) begin
                        state  <= DONE;
                        run_en <= 1'b0;
                        done0  <= gnt0;
                        done1  <= gnt1;
`ifdef SAT_GUARD_EN
                        sat_err <= sat_hit;
`endif
                    end else begin
                        remaining <= remaining - LEN_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    done0 <= 1'b0;
                    done1 <= 1'b0;
`ifdef SAT_GUARD_EN
                    sat_err <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_updown_counter_arbiter.sv
// Scoreboard bench: directed operations push expected completions; a monitor checks each done pulse.
module tb_updown_counter_arbiter;

    logic       clk;
    logic       rst;
    logic       req0, req1, dir0, dir1;
    logic [2:0] len0, len1;
    logic [2:0] count_m;
    logic       gnt0, gnt1, done0, done1, cnt_en, up_down, sat_err;
    logic       load_req;
    logic [2:0] load_val;

    typedef struct {
        int id;
        int steps;
        int fin;
        int dir;
        int sat;
        int gap;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   steps = 0;
    int   rise_cyc = 0;
    int   last_done = 0;
    logic prev_g = 1'b0;
    logic seen_dir = 1'b0;

    updown_counter_arbiter #(.LEN_W(3)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .dir0(dir0), .dir1(dir1),
        .len0(len0), .len1(len1), .count(count_m),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .cnt_en(cnt_en), .up_down(up_down), .sat_err(sat_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the shared 3-bit counter, wrapping naturally
    always @(posedge clk) begin
        if (load_req)
            count_m <= load_val;
        else if (cnt_en)
            count_m <= up_down ? count_m + 3'd1 : count_m - 3'd1;
    end

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic push(input int id, input int st, input int fin, input int dir, input int sat, input int gap);
        exp_t e;
        e.id = id; e.steps = st; e.fin = fin; e.dir = dir; e.sat = sat; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                steps  = 0;
                prev_g = 1'b0;
            end else begin
                chk("gnt_onehot", int'(gnt0 & gnt1), 0);
                if ((gnt0 | gnt1) && !prev_g) rise_cyc = cyc;
                prev_g = gnt0 | gnt1;
                if (cnt_en) begin
                    steps++;
                    seen_dir = up_down;
                end
                if (done0 | done1) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_id", int'(done1), e.id);
                        chk("done_both", int'(done0 & done1), 0);
                        chk("gnt_at_done", int'(e.id != 0 ? gnt1 : gnt0), 1);
                        chk("steps", steps, e.steps);
                        chk("final_count", int'(count_m), e.fin);
                        chk("sat_err", int'(sat_err), e.sat);
                        chk("cnt_en_in_done", int'(cnt_en), 0);
                        if (e.steps > 0) chk("direction", int'(seen_dir), e.dir);
                        if (e.gap != 0) chk("idle_gap", rise_cyc - last_done, 2);
                    end
                    steps     = 0;
                    last_done = cyc;
                end else begin
                    chk("stray_sat_err", int'(sat_err), 0);
                end
            end
        end
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(done0 | done1) && n < bound);
        chk("done_seen", int'(done0 | done1), 1);
    endtask

    task automatic wait_gnt(input int bound);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(gnt0 | gnt1) && n < bound);
        chk("gnt_seen", int'(gnt0 | gnt1), 1);
    endtask

    task automatic load(input logic [2:0] v);
        @(negedge clk);
        load_val = v;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt0"}, int'(gnt0), 0);
        chk({tag, "_gnt1"}, int'(gnt1), 0);
        chk({tag, "_done0"}, int'(done0), 0);
        chk({tag, "_done1"}, int'(done1), 0);
        chk({tag, "_cnt_en"}, int'(cnt_en), 0);
        chk({tag, "_up_down"}, int'(up_down), 0);
        chk({tag, "_sat_err"}, int'(sat_err), 0);
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; dir0 = 1'b0; dir1 = 1'b0;
        len0 = 3'd0; len1 = 3'd0;
        load_req = 1'b1; load_val = 3'd0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        load_req = 1'b0;

        // Single up operation, len 3, counter 0 -> 3
        push(0, 3, 3, 1, 0, 0);
        req0 = 1'b1; dir0 = 1'b1; len0 = 3'd3;
        @(posedge clk);
        #1;
        chk("first_gnt0", int'(gnt0), 1);
        chk("first_cnt_en", int'(cnt_en), 1);
        chk("first_up_down", int'(up_down), 1);
        wait_done(20);
        req0 = 1'b0;

        // Zero-length operation on requester 1: no counter steps
        repeat (2) @(negedge clk);
        push(1, 0, 3, 0, 0, 0);
        req1 = 1'b1; dir1 = 1'b0; len1 = 3'd0;
        wait_done(20);
        req1 = 1'b0;

        // Requester drops and inputs change mid-RUN; all 4 down steps still issued (6 -> 2)
        load(3'd6);
        push(0, 4, 2, 0, 0, 0);
        req0 = 1'b1; dir0 = 1'b0; len0 = 3'd4;
        wait_gnt(20);
        req0 = 1'b0; dir0 = 1'b1; len0 = 3'd1;
        wait_done(20);

        // Wrap versus saturation guard: start at 6, up, len 3
        load(3'd6);
`ifdef SAT_GUARD_EN
        push(0, 1, 7, 1, 1, 0);
`else
        push(0, 3, 1, 1, 0, 0);
`endif
        req0 = 1'b1; dir0 = 1'b1; len0 = 3'd3;
        wait_done(20);
        req0 = 1'b0;

        // Reset in the second RUN cycle of a len-5 operation
        load(3'd0);
        req0 = 1'b1; dir0 = 1'b1; len0 = 3'd5;
        wait_gnt(20);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req0 = 1'b0;
        @(posedge clk);
        #1 check_all_zero("abort");
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort_no_done_pending", exp_q.size(), 0);

        // Both requesters held: grants alternate 0,1,0,1 with one IDLE cycle between
        load(3'd0);
        push(0, 2, 2, 1, 0, 0);
        push(1, 2, 0, 0, 0, 1);
        push(0, 2, 2, 1, 0, 1);
        push(1, 2, 0, 0, 0, 1);
        dir0 = 1'b1; len0 = 3'd2; dir1 = 1'b0; len1 = 3'd2;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 3; k++) wait_done(20);
        wait_gnt(20);
        req0 = 1'b0; req1 = 1'b0;
        wait_done(20);

        repeat (6) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
